instruction_decode_queue: RTL and testbench

- Parametrised successor to the single-slot, three-state decoder.
- Accepts raw 32-bit instruction words with their PC from fetch and extracts fields and immediates internally.
- Decodes each accepted word in the same cycle and buffers the result, as instruction_element_t, in a DEPTH-entry FIFO with valid/ready on both sides.
- Adds over the previous decoder: back-to-back decode (one word per cycle), flush, illegal-instruction reporting, and funct7-qualified add/sub.

---
 rtl/instruction_decode_queue_pkg.sv | 93 +++++++++
 rtl/instruction_decode_queue_field_decode.sv | 164 ++++++++++++++++
 rtl/instruction_decode_queue.sv | 89 ++++++++
 tb/tb_instruction_decode_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_queue_pkg.sv
// Shared RV32I encodings, decoded-instruction element and immediate extraction
// for the decode queue and its field decoder.
package instruction_decode_queue_pkg;

  typedef enum logic [6:0] {
    op_load  = 7'b0000011,
    op_imm   = 7'b0010011,
    op_auipc = 7'b0010111,
    op_store = 7'b0100011,
    op_reg   = 7'b0110011,
    op_lui   = 7'b0110111,
    op_br    = 7'b1100011,
    op_jalr  = 7'b1100111,
    op_jal   = 7'b1101111
  } rv32i_opcode_t;

  typedef enum logic [2:0] {
    f3_beq  = 3'd0,
    f3_bne  = 3'd1,
    f3_blt  = 3'd4,
    f3_bge  = 3'd5,
    f3_bltu = 3'd6,
    f3_bgeu = 3'd7
  } branch_funct3_t;

  typedef enum logic [2:0] {
    f3_lb  = 3'd0,
    f3_lh  = 3'd1,
    f3_lw  = 3'd2,
    f3_lbu = 3'd4,
    f3_lhu = 3'd5
  } load_funct3_t;

  typedef enum logic [2:0] {
    f3_sb = 3'd0,
    f3_sh = 3'd1,
    f3_sw = 3'd2
  } store_funct3_t;

  typedef enum logic [2:0] {
    f3_add  = 3'd0,
    f3_sll  = 3'd1,
    f3_slt  = 3'd2,
    f3_sltu = 3'd3,
    f3_xor  = 3'd4,
    f3_sr   = 3'd5,
    f3_or   = 3'd6,
    f3_and  = 3'd7
  } arith_funct3_t;

  typedef enum logic [5:0] {
    illegal,
    lui, auipc, jal, jalr,
    br_beq, br_bne, br_blt, br_bge, br_bltu, br_bgeu,
    ld_lb, ld_lh, ld_lw, ld_lbu, ld_lhu,
    st_sb, st_sh, st_sw,
    imm_add, imm_slt, imm_sltu, imm_xor, imm_or, imm_and, imm_sll, imm_srl, imm_sra,
    rr_add, rr_sub, rr_sll, rr_slt, rr_sltu, rr_xor, rr_srl, rr_sra, rr_or, rr_and
  } instr_kind_t;

  typedef struct packed {
    instr_kind_t instruction;
    logic [31:0] pc;
    logic        cb1;
    logic [31:0] val1;
    logic        cb2;
    logic [31:0] val2;
    logic [4:0]  dest;
    logic        branch;
    logic [31:0] b_imm;
  } instruction_element_t;

  function automatic logic [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] w);
    return {w[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/instruction_decode_queue_field_decode.sv
// Combinational RV32I field decoder: raw word + PC to a queue element and an
// illegal flag. Illegal words decode to an element carrying only pc and kind.
module rv32i_field_decode
  import instruction_decode_queue_pkg::*;
(
  input  logic [31:0]          instr,
  input  logic [31:0]          pc,
  output instruction_element_t element,
  output logic                 illegal_flag
);

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        shift_f7_ok;

  assign f3          = instr[14:12];
  assign f7          = instr[31:25];
  assign rd          = instr[11:7];
  assign rs1_val     = {27'b0, instr[19:15]};
  assign rs2_val     = {27'b0, instr[24:20]};
  assign shift_f7_ok = (f7 == 7'h00) || (f7 == 7'h20);

  always_comb begin
    instruction_element_t el;
    logic bad;
    el        = '0;
    el.pc     = pc;
    bad       = (instr[1:0] != 2'b11);
    case (instr[6:0])
      op_lui: begin
        el.instruction = lui;
        el.val2        = imm_u(instr);
        el.dest        = rd;
      end
      op_auipc: begin
        el.instruction = auipc;
        el.val1        = pc;
        el.val2        = imm_u(instr);
        el.dest        = rd;
      end
      op_jal: begin
        el.instruction = jal;
        el.val1        = pc;
        el.val2        = imm_j(instr);
        el.dest        = rd;
        el.branch      = 1'b1;
      end
      op_jalr: begin
        el.instruction = jalr;
        el.cb1         = 1'b1;
        el.val1        = rs1_val;
        el.val2        = imm_i(instr);
        el.dest        = rd;
        el.branch      = 1'b1;
        bad            = bad | (f3 != 3'd0);
      end
      op_br: begin
        el.cb1    = 1'b1;
        el.cb2    = 1'b1;
        el.val1   = rs1_val;
        el.val2   = rs2_val;
        el.branch = 1'b1;
        el.b_imm  = imm_b(instr);
        case (f3)
          f3_beq:  el.instruction = br_beq;
          f3_bne:  el.instruction = br_bne;
          f3_blt:  el.instruction = br_blt;
          f3_bge:  el.instruction = br_bge;
          f3_bltu: el.instruction = br_bltu;
          f3_bgeu: el.instruction = br_bgeu;
          default: bad = 1'b1;
        endcase
      end
      op_load: begin
        el.cb1   = 1'b1;
        el.val1  = rs1_val;
        el.b_imm = imm_i(instr);
        el.dest  = rd;
        case (f3)
          f3_lb:   el.instruction = ld_lb;
          f3_lh:   el.instruction = ld_lh;
          f3_lw:   el.instruction = ld_lw;
          f3_lbu:  el.instruction = ld_lbu;
          f3_lhu:  el.instruction = ld_lhu;
          default: bad = 1'b1;
        endcase
      end
      op_store: begin
        el.cb1   = 1'b1;
        el.cb2   = 1'b1;
        el.val1  = rs1_val;
        el.val2  = rs2_val;
        el.b_imm = imm_s(instr);
        case (f3)
          f3_sb:   el.instruction = st_sb;
          f3_sh:   el.instruction = st_sh;
          f3_sw:   el.instruction = st_sw;
          default: bad = 1'b1;
        endcase
      end
      op_imm: begin
        el.cb1  = 1'b1;
        el.val1 = rs1_val;
        el.val2 = imm_i(instr);
        el.dest = rd;
        case (f3)
          f3_add:  el.instruction = imm_add;
          f3_slt:  el.instruction = imm_slt;
          f3_sltu: el.instruction = imm_sltu;
          f3_xor:  el.instruction = imm_xor;
          f3_or:   el.instruction = imm_or;
          f3_and:  el.instruction = imm_and;
          f3_sll: begin
            el.instruction = imm_sll;
            bad            = bad | ~shift_f7_ok;
          end
          default: begin
            el.instruction = f7[5] ? imm_sra : imm_srl;
            bad            = bad | ~shift_f7_ok;
          end
        endcase
      end
      op_reg: begin
        el.cb1  = 1'b1;
        el.cb2  = 1'b1;
        el.val1 = rs1_val;
        el.val2 = rs2_val;
        el.dest = rd;
        if (f7 == 7'h00) begin
          case (f3)
            f3_add:  el.instruction = rr_add;
            f3_sll:  el.instruction = rr_sll;
            f3_slt:  el.instruction = rr_slt;
            f3_sltu: el.instruction = rr_sltu;
            f3_xor:  el.instruction = rr_xor;
            f3_sr:   el.instruction = rr_srl;
            f3_or:   el.instruction = rr_or;
            default: el.instruction = rr_and;
          endcase
        end else if (f7 == 7'h20 && f3 == f3_add) begin
          el.instruction = rr_sub;
        end else if (f7 == 7'h20 && f3 == f3_sr) begin
          el.instruction = rr_sra;
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase

    // Illegal words carry only their PC so downstream can trap on them.
    if (bad) begin
      el             = '0;
      el.pc          = pc;
      el.instruction = illegal;
    end
    element      = el;
    illegal_flag = bad;
  end

endmodule

// File: rtl/instruction_decode_queue.sv
// Decode-and-buffer stage: decodes one fetched word per cycle into a DEPTH-entry
// FIFO of instruction elements, with flush and illegal-instruction reporting.
module instruction_decode_queue
  import instruction_decode_queue_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter bit DROP_ILLEGAL = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_vld_i,
  output logic                     fetch_rdy_o,
  input  logic [31:0]              instr_i,
  input  logic [31:0]              pc_i,
  input  logic                     flush_i,
  input  logic                     rdy_i,
  output logic                     vld_o,
  output instruction_element_t     instruction_o,
  output logic                     illegal_o,
  output logic [31:0]              illegal_pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  instruction_element_t storage [DEPTH];
  instruction_element_t dec_element;
  logic                 dec_illegal;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic                 accept;
  logic                 enq;
  logic                 deq;

  rv32i_field_decode u_field_decode (
    .instr        (instr_i),
    .pc           (pc_i),
    .element      (dec_element),
    .illegal_flag (dec_illegal)
  );

  assign fetch_rdy_o   = (count_o != CNT_W'(DEPTH));
  assign vld_o         = (count_o != '0);
  assign instruction_o = vld_o ? storage[rd_ptr] : '0;

  assign accept = fetch_vld_i & fetch_rdy_o;
  assign deq    = vld_o & rdy_i;
  assign enq    = accept & ~flush_i & ~(DROP_ILLEGAL & dec_illegal);

  // Storage holds data only; occupancy decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (enq) begin
      storage[wr_ptr] <= dec_element;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count_o      <= '0;
      illegal_o    <= 1'b0;
      illegal_pc_o <= '0;
    end else if (flush_i) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_o   <= '0;
      illegal_o <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_o <= count_o + CNT_W'(1);
        2'b01:   count_o <= count_o - CNT_W'(1);
        default: count_o <= count_o;
      endcase
      illegal_o <= accept & dec_illegal;
      if (accept & dec_illegal) begin
        illegal_pc_o <= pc_i;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Directed bench for instruction_decode_queue: one instance drops illegal words,
// a second (fed identically) enqueues them.
module tb_instruction_decode_queue;
  import instruction_decode_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_vld = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        rdy = 1'b0;

  logic                 fetch_rdy_d, vld_d, illegal_d;
  instruction_element_t ins_d;
  logic [31:0]          illegal_pc_d;
  logic [2:0]           count_d;
  logic                 fetch_rdy_k, vld_k, illegal_k;
  instruction_element_t ins_k;
  logic [31:0]          illegal_pc_k;
  logic [2:0]           count_k;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_decode_queue #(.DEPTH(4), .DROP_ILLEGAL(1'b1)) dut_drop (
    .clk(clk), .rst(rst), .fetch_vld_i(fetch_vld), .fetch_rdy_o(fetch_rdy_d),
    .instr_i(instr), .pc_i(pc), .flush_i(flush), .rdy_i(rdy), .vld_o(vld_d),
    .instruction_o(ins_d), .illegal_o(illegal_d), .illegal_pc_o(illegal_pc_d),
    .count_o(count_d)
  );

  instruction_decode_queue #(.DEPTH(4), .DROP_ILLEGAL(1'b0)) dut_keep (
    .clk(clk), .rst(rst), .fetch_vld_i(fetch_vld), .fetch_rdy_o(fetch_rdy_k),
    .instr_i(instr), .pc_i(pc), .flush_i(flush), .rdy_i(rdy), .vld_o(vld_k),
    .instruction_o(ins_k), .illegal_o(illegal_k), .illegal_pc_o(illegal_pc_k),
    .count_o(count_k)
  );

  function automatic instruction_element_t mk(input instr_kind_t k, input logic [31:0] p,
      input logic c1, input logic [31:0] v1, input logic c2, input logic [31:0] v2,
      input logic [4:0] d, input logic br, input logic [31:0] bi);
    instruction_element_t e;
    e.instruction = k; e.pc = p; e.cb1 = c1; e.val1 = v1; e.cb2 = c2; e.val2 = v2;
    e.dest = d; e.branch = br; e.b_imm = bi;
    return e;
  endfunction

  // Called at a falling edge; presents one word for exactly one rising edge.
  task automatic push(input logic [31:0] w, input logic [31:0] p);
    fetch_vld = 1'b1; instr = w; pc = p;
    @(negedge clk);
    fetch_vld = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (count_d !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_d); end
    checks++; if (vld_d !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", vld_d); end
    checks++; if (fetch_rdy_d !== 1'b1) begin errors++; $display("FAIL reset_fetch_rdy got %b exp 1", fetch_rdy_d); end
    checks++; if (illegal_d !== 1'b0 || illegal_pc_d !== 32'h0) begin errors++; $display("FAIL reset_illegal got %b/%h exp 0/0", illegal_d, illegal_pc_d); end
    checks++; if (ins_d !== '0) begin errors++; $display("FAIL reset_instruction got %h exp 0", ins_d); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addi;
    instruction_element_t e;
    e = mk(imm_add, 32'h100, 1'b1, 32'd0, 1'b0, 32'd5, 5'd1, 1'b0, 32'd0);
    rdy = 1'b0;
    push(32'h00500093, 32'h100);
    checks++; if (vld_d !== 1'b1 || count_d !== 3'd1) begin errors++; $display("FAIL addi_latency got vld=%b count=%0d exp 1/1", vld_d, count_d); end
    checks++; if (ins_d !== e) begin errors++; $display("FAIL addi_decode got %h exp %h", ins_d, e); end
    checks++; if (illegal_d !== 1'b0) begin errors++; $display("FAIL addi_no_illegal got %b exp 0", illegal_d); end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    checks++; if (vld_d !== 1'b0 || count_d !== 3'd0) begin errors++; $display("FAIL addi_pop got vld=%b count=%0d exp 0/0", vld_d, count_d); end
  endtask

  task automatic test_back_to_back;
    instruction_element_t exp_q [4];
    exp_q[0] = mk(rr_sub,  32'h104, 1'b1, 32'd1, 1'b1, 32'd2,     5'd3, 1'b0, 32'd0);
    exp_q[1] = mk(rr_add,  32'h108, 1'b1, 32'd1, 1'b1, 32'd2,     5'd3, 1'b0, 32'd0);
    exp_q[2] = mk(br_beq,  32'h200, 1'b1, 32'd1, 1'b1, 32'd2,     5'd0, 1'b1, 32'd8);
    exp_q[3] = mk(imm_sra, 32'h10C, 1'b1, 32'd1, 1'b0, 32'h403,   5'd2, 1'b0, 32'd0);
    push(32'h402081B3, 32'h104);
    push(32'h002081B3, 32'h108);
    push(32'h00208463, 32'h200);
    push(32'h4030D113, 32'h10C);
    checks++; if (count_d !== 3'd4 || fetch_rdy_d !== 1'b0) begin errors++; $display("FAIL b2b_fill got count=%0d rdy=%b exp 4/0", count_d, fetch_rdy_d); end
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ins_d !== exp_q[i]) begin errors++; $display("FAIL b2b_head%0d got %h exp %h", i, ins_d, exp_q[i]); end
      @(negedge clk);
    end
    rdy = 1'b0;
    checks++; if (count_d !== 3'd0) begin errors++; $display("FAIL b2b_drain got %0d exp 0", count_d); end
  endtask

  task automatic test_immediates;
    instruction_element_t e0, e1;
    e0 = mk(lui,     32'h110, 1'b0, 32'd0, 1'b0, 32'h12345000, 5'd5, 1'b0, 32'd0);
    e1 = mk(imm_add, 32'h114, 1'b1, 32'd0, 1'b0, 32'hFFFFFFFF, 5'd1, 1'b0, 32'd0);
    push(32'h123452B7, 32'h110);
    push(32'hFFF00093, 32'h114);
    rdy = 1'b1;
    checks++; if (ins_d !== e0) begin errors++; $display("FAIL lui_decode got %h exp %h", ins_d, e0); end
    @(negedge clk);
    checks++; if (ins_d !== e1) begin errors++; $display("FAIL addi_neg_decode got %h exp %h", ins_d, e1); end
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic test_full_wrap;
    for (int k = 1; k <= 4; k++) push(32'h00000093 | (k << 20), 32'h400 + 32'(4 * k));
    checks++; if (count_d !== 3'd4 || fetch_rdy_d !== 1'b0) begin errors++; $display("FAIL full_after4 got count=%0d rdy=%b exp 4/0", count_d, fetch_rdy_d); end
    fetch_vld = 1'b1; instr = 32'h00500093; pc = 32'h414;
    @(negedge clk);
    checks++; if (count_d !== 3'd4 || ins_d.val2 !== 32'd1) begin errors++; $display("FAIL full_reject got count=%0d head=%0d exp 4/1", count_d, ins_d.val2); end
    rdy = 1'b1;
    @(negedge clk);
    checks++; if (count_d !== 3'd3 || fetch_rdy_d !== 1'b1 || ins_d.val2 !== 32'd2) begin errors++; $display("FAIL full_free got count=%0d rdy=%b head=%0d exp 3/1/2", count_d, fetch_rdy_d, ins_d.val2); end
    @(negedge clk);
    fetch_vld = 1'b0;
    checks++; if (count_d !== 3'd3 || ins_d.val2 !== 32'd3) begin errors++; $display("FAIL full_refill got count=%0d head=%0d exp 3/3", count_d, ins_d.val2); end
    for (int k = 4; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (count_d !== 3'(6 - k) || ins_d.val2 !== 32'(k)) begin errors++; $display("FAIL full_order%0d got count=%0d head=%0d exp %0d/%0d", k, count_d, ins_d.val2, 6 - k, k); end
    end
    @(negedge clk);
    rdy = 1'b0;
    checks++; if (count_d !== 3'd0 || vld_d !== 1'b0) begin errors++; $display("FAIL full_empty got count=%0d vld=%b exp 0/0", count_d, vld_d); end
  endtask

  task automatic test_flush;
    for (int k = 1; k <= 3; k++) push(32'h00000093 | (k << 20), 32'h500 + 32'(4 * k));
    checks++; if (count_d !== 3'd3) begin errors++; $display("FAIL flush_prefill got %0d exp 3", count_d); end
    flush = 1'b1; rdy = 1'b1; fetch_vld = 1'b1; instr = 32'hFFFFFFFF; pc = 32'h510;
    @(negedge clk);
    flush = 1'b0; rdy = 1'b0; fetch_vld = 1'b0;
    checks++; if (count_d !== 3'd0 || vld_d !== 1'b0 || ins_d !== '0) begin errors++; $display("FAIL flush_clear got count=%0d vld=%b ins=%h exp 0/0/0", count_d, vld_d, ins_d); end
    checks++; if (illegal_d !== 1'b0 || count_k !== 3'd0) begin errors++; $display("FAIL flush_suppress got ill=%b count_k=%0d exp 0/0", illegal_d, count_k); end
    push(32'h00700093, 32'h600);
    checks++; if (count_d !== 3'd1 || ins_d.val2 !== 32'd7 || ins_d.pc !== 32'h600) begin errors++; $display("FAIL flush_resume got count=%0d val2=%0d pc=%h exp 1/7/600", count_d, ins_d.val2, ins_d.pc); end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic test_illegal;
    instruction_element_t e;
    e = mk(illegal, 32'h300, 1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    push(32'hFFFFFFFF, 32'h300);
    checks++; if (illegal_d !== 1'b1 || illegal_pc_d !== 32'h300) begin errors++; $display("FAIL illegal_pulse got %b/%h exp 1/300", illegal_d, illegal_pc_d); end
    checks++; if (count_d !== 3'd0 || vld_d !== 1'b0) begin errors++; $display("FAIL illegal_dropped got count=%0d vld=%b exp 0/0", count_d, vld_d); end
    checks++; if (count_k !== 3'd1 || vld_k !== 1'b1 || ins_k !== e) begin errors++; $display("FAIL illegal_kept got count=%0d ins=%h exp 1/%h", count_k, ins_k, e); end
    checks++; if (illegal_k !== 1'b1 || illegal_pc_k !== 32'h300 || fetch_rdy_k !== 1'b1) begin errors++; $display("FAIL illegal_keep_report got %b/%h/%b exp 1/300/1", illegal_k, illegal_pc_k, fetch_rdy_k); end
    @(negedge clk);
    checks++; if (illegal_d !== 1'b0 || illegal_pc_d !== 32'h300) begin errors++; $display("FAIL illegal_one_cycle got %b/%h exp 0/300", illegal_d, illegal_pc_d); end
    push(32'h022081B3, 32'h304);
    checks++; if (illegal_d !== 1'b1 || illegal_pc_d !== 32'h304 || count_d !== 3'd0) begin errors++; $display("FAIL illegal_funct7 got %b/%h/%0d exp 1/304/0", illegal_d, illegal_pc_d, count_d); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset_mid;
    push(32'h00100093, 32'h700);
    push(32'h00200093, 32'h704);
    checks++; if (count_d !== 3'd2) begin errors++; $display("FAIL midrst_prefill got %0d exp 2", count_d); end
    #2 rst = 1'b0;
    #1;
    checks++; if (count_d !== 3'd0 || vld_d !== 1'b0 || fetch_rdy_d !== 1'b1) begin errors++; $display("FAIL midrst_async got count=%0d vld=%b rdy=%b exp 0/0/1", count_d, vld_d, fetch_rdy_d); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (count_d !== 3'd0 || ins_d !== '0) begin errors++; $display("FAIL midrst_empty got count=%0d ins=%h exp 0/0", count_d, ins_d); end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_back_to_back;
    test_immediates;
    test_full_wrap;
    test_flush;
    test_illegal;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
